// File: rtl/uart_loader.sv
// Boot loader: frames host bytes from the UART receiver into memory words,
// holds the CPU in halt during download and verifies an XOR checksum.
module uart_loader #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    WORD_BYTES     = 2,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    BASE_ADDR      = 0,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
  parameter int                    TIMEOUT_CYCLES = 2000000
) (
  input  logic                             in_clk,
  input  logic                             in_rst,
  input  logic                             in_start,
  input  logic [DATA_WIDTH-1:0]            in_rx_data,
  input  logic                             in_rx_done,
  output logic                             out_rx_en,
  output logic                             out_halt,
  output logic                             out_mem_we,
  output logic [ADDR_WIDTH-1:0]            out_mem_addr,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] out_mem_data,
  output logic                             out_busy,
  output logic                             out_done,
  output logic                             out_err
);

  localparam int WW  = DATA_WIDTH * WORD_BYTES;
  localparam int BIW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned MAXW = (32'd1 << ADDR_WIDTH) - BASE_ADDR;
  localparam logic [TW-1:0]  TMAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BIW-1:0] BLAST = BIW'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, COUNT, DATA, CHECK, DONE, ERR
  } state_t;

  state_t                  state_q;
  logic                    rx_done_q;
  logic [DATA_WIDTH-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0]   chk_q;
  logic [ADDR_WIDTH:0]     wi_q;
  logic [BIW-1:0]          bi_q;
  logic [TW-1:0]           tmo_q;
  logic [WW-1:0]           word_q;
  logic [WW-1:0]           word_d;
  logic                    accept;
  logic                    timed;

  assign accept = in_rx_done & ~rx_done_q & out_rx_en;
  assign timed  = (state_q == COUNT || state_q == DATA ||
                   state_q == CHECK);

  // Little-endian merge of the incoming byte into the word buffer
  always_comb begin
    word_d = word_q;
    word_d[DATA_WIDTH*int'(bi_q) +: DATA_WIDTH] = in_rx_data;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= IDLE;
      rx_done_q    <= 1'b0;
      cnt_q        <= '0;
      chk_q        <= '0;
      wi_q         <= '0;
      bi_q         <= '0;
      tmo_q        <= '0;
      word_q       <= '0;
      out_rx_en    <= 1'b0;
      out_halt     <= 1'b0;
      out_mem_we   <= 1'b0;
      out_mem_addr <= '0;
      out_mem_data <= '0;
      out_busy     <= 1'b0;
      out_done     <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      rx_done_q  <= in_rx_done;
      out_mem_we <= 1'b0;
      out_done   <= 1'b0;
      if (timed)
        tmo_q <= accept ? '0 : tmo_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (in_start) begin
            state_q   <= SYNC;
            out_err   <= 1'b0;
            chk_q     <= '0;
            wi_q      <= '0;
            bi_q      <= '0;
            tmo_q     <= '0;
            out_rx_en <= 1'b1;
            out_halt  <= 1'b1;
            out_busy  <= 1'b1;
          end
        end
        SYNC: begin
          tmo_q <= '0;
          if (accept && in_rx_data == SYNC_BYTE)
            state_q <= COUNT;
        end
        COUNT: begin
          if (accept) begin
            cnt_q <= in_rx_data;
            if (in_rx_data == '0 || 32'(in_rx_data) > MAXW) begin
              state_q <= ERR;
              out_err <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word_q <= word_d;
            chk_q  <= chk_q ^ in_rx_data;
            if (bi_q == BLAST) begin
              out_mem_we   <= 1'b1;
              out_mem_addr <= ADDR_WIDTH'(BASE_ADDR) +
                              wi_q[ADDR_WIDTH-1:0];
              out_mem_data <= word_d;
              bi_q         <= '0;
              wi_q         <= wi_q + 1'b1;
              if (32'(wi_q) + 32'd1 == 32'(cnt_q))
                state_q <= CHECK;
            end else begin
              bi_q <= bi_q + 1'b1;
            end
          end
        end
        CHECK: begin
          if (accept) begin
            if (in_rx_data == chk_q) begin
              state_q  <= DONE;
              out_done <= 1'b1;
            end else begin
              state_q <= ERR;
              out_err <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          state_q   <= IDLE;
          out_rx_en <= 1'b0;
          out_halt  <= 1'b0;
          out_busy  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      // Host went silent inside a frame
      if (timed && !accept && tmo_q == TMAX) begin
        state_q <= ERR;
        out_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized self-checking bench for uart_loader against a frame-level
// reference model.
module tb_uart_loader;

  localparam int DW  = 8;
  localparam int WB  = 2;
  localparam int AW  = 8;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] rx_data;
  logic          rx_done;
  logic          rx_en, halt, we, busy, done, err;
  logic [AW-1:0] addr;
  logic [DW*WB-1:0] wdata;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  uart_loader #(
    .DATA_WIDTH(DW), .WORD_BYTES(WB), .ADDR_WIDTH(AW),
    .BASE_ADDR(0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .in_clk(clk), .in_rst(rst), .in_start(start),
    .in_rx_data(rx_data), .in_rx_done(rx_done),
    .out_rx_en(rx_en), .out_halt(halt), .out_mem_we(we),
    .out_mem_addr(addr), .out_mem_data(wdata),
    .out_busy(busy), .out_done(done), .out_err(err)
  );

  always @(negedge clk) begin
    if (we) got_q.push_back({8'h0, addr, wdata});
    if (done) n_done++;
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
  endtask

  task automatic send(logic [7:0] b, int hold, int gap);
    rx_data = b;
    rx_done = 1'b1;
    cyc(hold);
    rx_done = 1'b0;
    cyc(gap);
  endtask

  task automatic wait_idle(string tag);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cyc(1);
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic clear_log();
    got_q.delete();
    n_done = 0;
  endtask

  // Reference: parse a byte stream and predict writes, done and error
  task automatic model(input logic [7:0] s[$],
                       output logic [31:0] wr[$],
                       output int ok, output int bad);
    int p, n;
    logic [7:0] x;
    logic [15:0] w;
    wr.delete();
    ok = 0;
    bad = 0;
    p = 0;
    while (p < s.size() && s[p] != 8'hA5) p++;
    p++;
    if (p >= s.size()) return;
    n = s[p];
    p++;
    if (n == 0 || n > 256) begin
      bad = 1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = 16'h0;
      for (int k = 0; k < WB; k++) begin
        w = w | (16'(s[p]) << (8 * k));
        x = x ^ s[p];
        p++;
      end
      wr.push_back({8'h0, 8'(i), w});
    end
    if (s[p] == x) ok = 1;
    else bad = 1;
  endtask

  task automatic run_frame(string tag, logic [7:0] s[$],
                           int hold, int gap);
    logic [31:0] wr[$];
    int ok, bad;
    model(s, wr, ok, bad);
    clear_log();
    pulse_start();
    foreach (s[i]) send(s[i], hold, gap);
    wait_idle({tag, "_idle"});
    check({tag, "_nwr"}, got_q.size(), wr.size());
    foreach (wr[i])
      if (i < got_q.size())
        check({tag, "_wr"}, got_q[i], wr[i]);
    check({tag, "_done"}, n_done, ok);
    check({tag, "_err"}, {31'b0, err}, bad);
    check({tag, "_halt"}, {31'b0, halt}, 32'd0);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] x;
    int n;
    rst = 1'b1;
    start = 1'b0;
    rx_data = '0;
    rx_done = 1'b0;
    cyc(3);
    check("rst_outs",
          {24'b0, rx_en, halt, we, busy, done, err, |addr, |wdata},
          32'd0);
    rst = 1'b0;
    cyc(2);

    run_frame("dflt", '{8'hA5, 8'h02, 8'h34, 8'h12,
                        8'h78, 8'h56, 8'h08}, 1, 6);
    run_frame("badchk", '{8'hA5, 8'h02, 8'h34, 8'h12,
                          8'h78, 8'h56, 8'h09}, 1, 6);
    pulse_start();
    check("err_clr", {31'b0, err}, 32'd0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);

    run_frame("noise", '{8'h00, 8'hFF, 8'hA5, 8'h01,
                         8'hCD, 8'hAB, 8'h66}, 1, 5);
    run_frame("zero", '{8'hA5, 8'h00}, 1, 5);
    run_frame("stuck", '{8'hA5, 8'h01, 8'hCD, 8'hAB, 8'h66}, 5, 4);

    // Silence mid-word must time out without a write
    clear_log();
    pulse_start();
    send(8'hA5, 1, 4);
    send(8'h01, 1, 4);
    send(8'h11, 1, 4);
    cyc(TMO - 10);
    check("tmo_early", {31'b0, err}, 32'd0);
    wait_idle("tmo_idle");
    check("tmo_err", {31'b0, err}, 32'd1);
    check("tmo_nwr", got_q.size(), 32'd0);
    check("tmo_halt", {31'b0, halt}, 32'd0);

    // Reset between the two bytes of a word
    clear_log();
    pulse_start();
    send(8'hA5, 1, 4);
    send(8'h01, 1, 4);
    send(8'h34, 1, 2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mrst_outs",
          {26'b0, rx_en, halt, we, busy, done, err}, 32'd0);
    send(8'h12, 1, 6);
    check("mrst_nwr", got_q.size(), 32'd0);
    check("mrst_halt", {31'b0, halt}, 32'd0);

    for (int t = 0; t < 10; t++) begin
      s.delete();
      repeat ($urandom_range(0, 3)) begin
        x = 8'($urandom_range(0, 255));
        if (x == 8'hA5) x = 8'h5A;
        s.push_back(x);
      end
      n = $urandom_range(1, 5);
      s.push_back(8'hA5);
      s.push_back(8'(n));
      x = 8'h00;
      repeat (n * WB) begin
        s.push_back(8'($urandom_range(0, 255)));
        x = x ^ s[s.size() - 1];
      end
      if ($urandom_range(0, 1) == 1)
        x = x ^ 8'($urandom_range(1, 255));
      s.push_back(x);
      run_frame("rand", s, $urandom_range(1, 3),
                $urandom_range(3, 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Sequences the serial byte receiver to download a program image from a host into instruction/data memory.
- Enables the receiver, parses a framed byte stream, and assembles bytes into memory words.
- Issues one memory write per word and verifies an XOR checksum.
- Holds the CPU in halt for the whole download; sits between the receiver's byte/done outputs and the memory write port.

Parameters:
DATA_WIDTH, 8, byte width delivered by receiver
WORD_BYTES, 2, bytes per memory word (>=1)
ADDR_WIDTH, 8, memory address width
BASE_ADDR, 0, address of first word written
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 2000000, max in_clk cycles between bytes inside a frame

Ports:
in_clk  input  1  clock
in_rst  input  1  synchronous reset, active-high
in_start  input  1  one-cycle request to begin a download
in_rx_data  input  DATA_WIDTH  byte from receiver
in_rx_done  input  1  receiver byte-complete strobe
out_rx_en  output  1  enable to receiver
out_halt  output  1  CPU halt request
out_mem_we  output  1  memory write strobe
out_mem_addr  output  ADDR_WIDTH  write address
out_mem_data  output  DATA_WIDTH*WORD_BYTES  write data
out_busy  output  1  download in progress
out_done  output  1  one-cycle success pulse
out_err  output  1  sticky error flag

Behaviour:
- Clock and reset: single clock in_clk. in_rst is synchronous and active-high. Reset overrides all other inputs in the same cycle.
- Reset values: all outputs 0; state IDLE; all counters, the checksum and the word buffer 0.
- Byte accept: the rising edge of in_rx_done (in_rx_done=1 and its registered copy=0). A strobe held high counts as one byte. Bytes are accepted only when out_rx_en=1.
- IDLE:
  - out_rx_en=0, out_halt=0, out_busy=0.
  - in_start=1 -> SYNC. On that same edge: clear out_err, checksum, word index and byte index.
- SYNC:
  - out_rx_en=1, out_halt=1, out_busy=1.
  - Accepted byte == SYNC_BYTE -> COUNT. Any other byte is discarded.
  - No timeout in this state.
- COUNT:
  - Accepted byte N latched as word count.
  - N==0 -> ERR.
  - N > 2^ADDR_WIDTH - BASE_ADDR -> ERR.
  - Otherwise -> DATA.
- DATA:
  - Each accepted byte is placed little-endian: byte index k goes to word bits [8k+7:8k]. Checksum ^= byte.
  - When byte index reaches WORD_BYTES-1: on the next cycle out_mem_we=1 for exactly one cycle, out_mem_addr=BASE_ADDR+word index, out_mem_data=the assembled word.
  - Word index increments after the write; byte index wraps to 0.
  - After word N-1 is written -> CHECK.
  - The last byte's write strobe precedes any CHECK byte acceptance. Minimum byte spacing is many cycles, so no collision occurs.
- CHECK:
  - Accepted byte == checksum -> DONE; else -> ERR.
- DONE: out_done=1 for one cycle, then IDLE. out_halt and out_rx_en drop on the IDLE cycle.
- ERR: out_err=1 (stays set through IDLE until the next in_start or reset), then IDLE next cycle. Memory writes already issued are not undone.
- Timeout:
  - A counter runs in COUNT, DATA and CHECK and clears on each accepted byte.
  - Reaching TIMEOUT_CYCLES-1 -> ERR.
- in_start while not IDLE: ignored.
- Reset mid-frame: immediate return to IDLE. No further write strobes; halt released the next cycle.
- out_mem_addr and out_mem_data hold their last values when out_mem_we=0.
- Widths:
  - Word index is ADDR_WIDTH+1 bits; address addition wraps modulo 2^ADDR_WIDTH (unreachable after the COUNT check).
  - Timeout counter is $clog2(TIMEOUT_CYCLES) bits.

Test Plan:
- Defaults. Reset, in_start, bytes A5,02,34,12,78,56,chk=0x08 -> two writes: addr0=0x1234, addr1=0x5678. Then out_done pulse; out_err=0; out_halt returns to 0.
- Bad checksum. Same frame with chk=0x09 -> both writes occur, no out_done, out_err=1. out_err clears on the next in_start.
- Noise before sync. Bytes 00,FF,A5,01,CD,AB,66 -> garbage ignored; single write addr0=0xABCD; out_done pulses.
- Zero count. A5,00 -> out_err=1, no out_mem_we.
- Timeout. A5,01,11, then silence for TIMEOUT_CYCLES (use a small parameter, e.g. 50) -> out_err=1 at cycle 50; no write; halt released.
- Mid-frame reset plus stuck strobe. in_rst asserted between byte 1 and byte 2 of a word -> no write, all outputs 0. A done strobe held high for 5 cycles is counted as one byte.
